// File: rtl/proc_run_ctrl.sv
// Run controller for Proc cores: core reset sequencing, run-cycle counting, sticky halt
// collection, drain window and watchdog. Define PROC_RUN_TRACE_EN for a simulation trace.
module proc_run_ctrl #(
  parameter int NCORES       = 1,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 8,
  parameter int MAX_CYCLES   = 100000,
  parameter int HALT_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCORES-1:0] halt,
  input  logic              restart,
  output logic              core_rst_n,
  output logic              run_done,
  output logic              timeout,
  output logic [NCORES-1:0] halt_mask,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  halt_cycle
);
  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_t;

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [DRAIN_W-1:0]  drain_cnt, drain_n;
  logic [NCORES-1:0]   mask_acc, mask_n;
  logic [CNT_W-1:0]    cnt_inc, cnt_n, hcyc_n;
  logic                halt_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HOLD;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    drain_n  = drain_cnt;
    mask_n   = halt_mask;
    cnt_n    = cycle_count;
    hcyc_n   = halt_cycle;
    mask_acc = halt_mask | halt;
    cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    // Halt condition is judged on the mask including this cycle's halt inputs.
    halt_hit = (HALT_MODE != 0) ? (|mask_acc) : (&mask_acc);
    case (state)
      S_HOLD: begin
        hold_n = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_n = S_RUN;
      end
      S_RUN: begin
        cnt_n  = cnt_inc;
        mask_n = mask_acc;
        if (halt_hit) begin
          hcyc_n  = cnt_inc;
          drain_n = '0;
          state_n = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (MAX_CYCLES != 0 && 64'(cnt_inc) == 64'(MAX_CYCLES)) begin
          state_n = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        mask_n  = mask_acc;
        drain_n = drain_cnt + DRAIN_W'(1);
        if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_n = S_DONE;
      end
      S_DONE, S_TIMEOUT: begin
        if (restart) begin
          state_n = S_HOLD;
          hold_n  = '0;
          mask_n  = '0;
          cnt_n   = '0;
          hcyc_n  = '0;
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      halt_mask   <= '0;
      cycle_count <= '0;
      halt_cycle  <= '0;
      core_rst_n  <= 1'b0;
      run_done    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      hold_cnt    <= hold_n;
      drain_cnt   <= drain_n;
      halt_mask   <= mask_n;
      cycle_count <= cnt_n;
      halt_cycle  <= hcyc_n;
      core_rst_n  <= (state_n != S_HOLD);
      run_done    <= (state_n == S_DONE) || (state_n == S_TIMEOUT);
      timeout     <= (state_n == S_TIMEOUT);
    end
  end

`ifdef PROC_RUN_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NCORES; i++)
        if (mask_n[i] && !halt_mask[i])
          $display("%0t proc_run_ctrl: core %0d halted, cycle_count=%0d", $time, i, cnt_n);
      if (state_n == S_DONE && state != S_DONE)
        $display("%0t proc_run_ctrl: run done, halt_cycle=%0d", $time, hcyc_n);
      if (state_n == S_TIMEOUT && state != S_TIMEOUT)
        $display("%0t proc_run_ctrl: watchdog, cycle_count=%0d", $time, cnt_n);
    end
  end
`endif

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed table on a single-core instance, T3 and randomized runs
// on two four-core instances against an outcome model, plus reset and saturation sequences.
module tb_proc_run_ctrl;
  localparam int RS_A = 4, DR_A = 8, MX_A = 50;
  localparam int RS_B = 1, DR_B = 5, MX_B = 60;
  localparam int RS_C = 2, DR_C = 0, MX_C = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  logic        rst_a, rs_a, crn_a, done_a, to_a;
  logic [0:0]  halt_a, mask_a;
  logic [31:0] cc_a, hc_a;
  logic        rst_bc, rs_bc, crn_b, done_b, to_b, crn_c, done_c, to_c;
  logic [3:0]  halt_b, halt_c, mask_b, mask_c;
  logic [15:0] cc_b, hc_b;
  logic [7:0]  cc_c, hc_c;
  logic        rst_d, rs_d, crn_d, done_d, to_d;
  logic [0:0]  halt_d, mask_d;
  logic [3:0]  cc_d, hc_d;

  proc_run_ctrl #(.NCORES(1), .CNT_W(32), .RST_CYCLES(RS_A), .DRAIN_CYCLES(DR_A),
    .MAX_CYCLES(MX_A), .HALT_MODE(0)) u_a (.clk(clk), .rst_n(rst_a), .halt(halt_a),
    .restart(rs_a), .core_rst_n(crn_a), .run_done(done_a), .timeout(to_a),
    .halt_mask(mask_a), .cycle_count(cc_a), .halt_cycle(hc_a));
  proc_run_ctrl #(.NCORES(4), .CNT_W(16), .RST_CYCLES(RS_B), .DRAIN_CYCLES(DR_B),
    .MAX_CYCLES(MX_B), .HALT_MODE(0)) u_b (.clk(clk), .rst_n(rst_bc), .halt(halt_b),
    .restart(rs_bc), .core_rst_n(crn_b), .run_done(done_b), .timeout(to_b),
    .halt_mask(mask_b), .cycle_count(cc_b), .halt_cycle(hc_b));
  proc_run_ctrl #(.NCORES(4), .CNT_W(8), .RST_CYCLES(RS_C), .DRAIN_CYCLES(DR_C),
    .MAX_CYCLES(MX_C), .HALT_MODE(1)) u_c (.clk(clk), .rst_n(rst_bc), .halt(halt_c),
    .restart(rs_bc), .core_rst_n(crn_c), .run_done(done_c), .timeout(to_c),
    .halt_mask(mask_c), .cycle_count(cc_c), .halt_cycle(hc_c));
  proc_run_ctrl #(.NCORES(1), .CNT_W(4), .RST_CYCLES(1), .DRAIN_CYCLES(1),
    .MAX_CYCLES(0), .HALT_MODE(0)) u_d (.clk(clk), .rst_n(rst_d), .halt(halt_d),
    .restart(rs_d), .core_rst_n(crn_d), .run_done(done_d), .timeout(to_d),
    .halt_mask(mask_d), .cycle_count(cc_d), .halt_cycle(hc_d));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a run from the per-core first-halt cycles (0 = never halts).
  function automatic void model(input int mode, input int drain, input int maxc, input int rstc,
                                input int hh[4], output int dedge, output bit tov,
                                output int ccv, output int hcv, output int lim);
    int c = -1, mx = 0;
    bit all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (hh[i] == 0) all = 1'b0;
      else begin
        if (c < 0 || hh[i] < c) c = hh[i];
        if (hh[i] > mx) mx = hh[i];
      end
    end
    if (mode == 0) c = all ? mx : -1;
    if (c > 0 && (maxc == 0 || c <= maxc)) begin
      tov = 1'b0; ccv = c; hcv = c; lim = c + drain; dedge = rstc + c + drain;
    end else begin
      tov = 1'b1; ccv = maxc; hcv = 0; lim = maxc; dedge = rstc + maxc;
    end
  endfunction

  function automatic logic [3:0] exp_mask(input int hh[4], input int k, input int lim);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (hh[i] != 0 && hh[i] <= k && hh[i] <= lim) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic hbit(input int h, input int k, input bit noise);
    if (k <= 0) return 1'($urandom_range(0, 1));
    if (h == 0 || k < h) return 1'b0;
    if (k == h || !noise) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_edge(input string nm, input int e, input int rstc, input int d,
                            input bit tov, input int ccv, input int hcv, input int lim,
                            input int hh[4], input logic crn, input logic dn, input logic to,
                            input logic [3:0] m, input logic [63:0] cc, input logic [63:0] hc);
    int k;
    k = e - rstc;
    chk($sformatf("%s e%0d core_rst_n", nm, e), crn, e >= rstc);
    chk($sformatf("%s e%0d run_done", nm, e), dn, e >= d);
    chk($sformatf("%s e%0d timeout", nm, e), to, tov && e >= d);
    chk($sformatf("%s e%0d halt_mask", nm, e), m, exp_mask(hh, k, lim));
    chk($sformatf("%s e%0d cycle_count", nm, e), cc, (k <= 0) ? 0 : ((k < ccv) ? k : ccv));
    chk($sformatf("%s e%0d halt_cycle", nm, e), hc, (hcv != 0 && k >= hcv) ? hcv : 0);
  endtask

  typedef struct {
    int   h;      // RUN cycle of the single halt pulse (0 = none)
    int   rs;     // RUN cycle of an ignored restart pulse (0 = none)
    logic to;
    int   cc;
    int   hc;
    logic mask;
    int   dedge;  // clock edge after reset/restart on which run_done rises
  } vec_a_t;

  task automatic run_a(input vec_a_t v, input int idx);
    int hh[4];
    int e_done;
    string nm;
    hh = '{v.h, 0, 0, 0};
    e_done = 0;
    nm = $sformatf("A%0d", idx);
    for (int e = 1; e <= v.dedge + 2; e++) begin
      int k;
      k = e - RS_A;
      halt_a = (k <= 0) ? 1'b1 : ((k == v.h) ? 1'b1 : 1'b0);
      rs_a   = (e == 1) || (v.rs != 0 && k == v.rs);
      tick();
      check_edge(nm, e, RS_A, v.dedge, v.to, v.cc, v.hc, v.to ? MX_A : v.cc + DR_A, hh,
                 crn_a, done_a, to_a, {3'b0, mask_a}, cc_a, hc_a);
      if (done_a && e_done == 0) e_done = e;
    end
    rs_a = 1'b0;
    halt_a = 1'b1;
    tick();
    chk({nm, " done_edge"}, e_done, v.dedge);
    chk({nm, " final timeout"}, to_a, v.to);
    chk({nm, " final cycle_count"}, cc_a, v.cc);
    chk({nm, " final halt_cycle"}, hc_a, v.hc);
    chk({nm, " final halt_mask"}, mask_a, v.mask);
    rs_a = 1'b1;
    tick();
    rs_a = 1'b0;
    halt_a = 1'b0;
    chk({nm, " restart core_rst_n"}, crn_a, 0);
    chk({nm, " restart status"}, {done_a, to_a, mask_a}, 0);
    chk({nm, " restart counters"}, {cc_a, hc_a}, 0);
  endtask

  task automatic run_pair(input int hh[4], input bit noise, input string tag);
    int db, dc, ccb, ccc, hcb, hcc, lb, lc, emax, mid;
    bit tob, toc;
    model(0, DR_B, MX_B, RS_B, hh, db, tob, ccb, hcb, lb);
    model(1, DR_C, MX_C, RS_C, hh, dc, toc, ccc, hcc, lc);
    emax = ((db > dc) ? db : dc) + 2;
    mid  = ((db < dc) ? db : dc) - 1;
    for (int e = 1; e <= emax; e++) begin
      for (int i = 0; i < 4; i++) begin
        halt_b[i] = hbit(hh[i], e - RS_B, noise);
        halt_c[i] = hbit(hh[i], e - RS_C, noise);
      end
      rs_bc = (e == 1) || (e == mid && mid > 1);
      tick();
      check_edge({tag, " B"}, e, RS_B, db, tob, ccb, hcb, lb, hh, crn_b, done_b, to_b,
                 mask_b, cc_b, hc_b);
      check_edge({tag, " C"}, e, RS_C, dc, toc, ccc, hcc, lc, hh, crn_c, done_c, to_c,
                 mask_c, cc_c, hc_c);
    end
    rs_bc = 1'b1;
    tick();
    rs_bc = 1'b0;
    halt_b = '0;
    halt_c = '0;
    chk({tag, " restart B"}, {crn_b, done_b, to_b, mask_b, cc_b, hc_b}, 0);
    chk({tag, " restart C"}, {crn_c, done_c, to_c, mask_c, cc_c, hc_c}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_a_t tbl[5];
    int hh[4];
    tbl[0] = '{20, 25, 1'b0, 20, 20, 1'b1, 32};
    tbl[1] = '{50, 10, 1'b0, 50, 50, 1'b1, 62};
    tbl[2] = '{51,  0, 1'b1, 50,  0, 1'b0, 54};
    tbl[3] = '{ 0,  5, 1'b1, 50,  0, 1'b0, 54};
    tbl[4] = '{ 1,  0, 1'b0,  1,  1, 1'b1, 13};

    rst_a = 1'b0; rst_bc = 1'b0; rst_d = 1'b0;
    rs_a = 1'b0; rs_bc = 1'b0; rs_d = 1'b0;
    halt_a = 1'b1; halt_b = '1; halt_c = '1; halt_d = 1'b1;
    tick();
    tick();
    chk("reset A core_rst_n", crn_a, 0);
    chk("reset A status", {done_a, to_a, mask_a}, 0);
    chk("reset A counters", {cc_a, hc_a}, 0);
    chk("reset BC core_rst_n", {crn_b, crn_c}, 0);
    chk("reset BC status", {done_b, to_b, mask_b, done_c, to_c, mask_c}, 0);
    chk("reset D counters", {crn_d, cc_d, hc_d}, 0);

    rst_a = 1'b1;
    for (int t = 0; t < 5; t++) run_a(tbl[t], t);

    // Asynchronous reset in the middle of a run, then the hold sequence again.
    halt_a = 1'b0;
    for (int e = 1; e <= RS_A + 10; e++) tick();
    chk("T6 cycle_count before reset", cc_a, 10);
    #2 rst_a = 1'b0;
    #1;
    chk("T6 async core_rst_n", crn_a, 0);
    chk("T6 async status", {done_a, to_a, mask_a}, 0);
    chk("T6 async counters", {cc_a, hc_a}, 0);
    rst_a = 1'b1;
    for (int e = 1; e <= RS_A; e++) begin
      tick();
      chk($sformatf("T6 rehold e%0d core_rst_n", e), crn_a, e >= RS_A);
      chk($sformatf("T6 rehold e%0d cycle_count", e), cc_a, 0);
    end

    rst_bc = 1'b1;
    hh = '{5, 9, 12, 30};
    run_pair(hh, 1'b0, "T3");
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++)
        hh[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 70));
      run_pair(hh, 1'b1, $sformatf("R%0d", r));
    end

    // Narrow counter with no watchdog: cycle_count must stick at all-ones.
    halt_d = 1'b0;
    rst_d = 1'b1;
    tick();
    chk("D core_rst_n", crn_d, 1);
    for (int e = 0; e < 20; e++) tick();
    chk("D saturated cycle_count", cc_d, 15);
    chk("D no watchdog", done_d, 0);
    halt_d = 1'b1;
    tick();
    halt_d = 1'b0;
    chk("D halt_cycle at saturation", hc_d, 15);
    tick();
    chk("D run_done after drain", {done_d, to_d, cc_d}, {1'b1, 1'b0, 4'd15});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
